dm_cmd_sequencer: RTL and testbench
===================================

Name: dm_cmd_sequencer

Overview:
Debug-module abstract-command controller.
- Owns Data0..Data(DATA_COUNT-1), AbstractCS and Command.
- Serves DMI-side CSR reads and writes through a valid/ready request/response handshake.
- Sequences one abstract command at a time to the hart: go pulse, then wait for done or exception.
- Sits between the DMI front end and the hart debug interface.

Parameters:
DATA_COUNT, 2, number of implemented data registers (1..12); Data0 at 8'h04, last at 8'h04+DATA_COUNT-1

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; one clock; reset is synchronous and active-low
dmi_req_valid_i  in  1  request valid
dmi_req_ready_o  out  1  request accepted when valid&ready
dmi_req_addr_i  in  7  CSR word address
dmi_req_op_i  in  2  0 nop, 1 read, 2 write, 3 reserved (treated as nop)
dmi_req_data_i  in  32  write data
dmi_resp_valid_o  out  1  response valid
dmi_resp_ready_i  in  1  response consumed
dmi_resp_data_o  out  32  read data (0 for write/nop)
go_o  out  1  one-cycle command launch pulse
cmd_o  out  32  latched Command value, stable while busy_o
hart_halted_i  in  1  hart is halted
hart_done_i  in  1  command completed
hart_exception_i  in  1  command faulted
hart_data_we_i  in  1  hart writes a data register
hart_data_idx_i  in  4  data register index
hart_data_i  in  32  hart write data
busy_o  out  1  AbstractCS.busy

Behaviour:
Reset:
- All outputs 0.
- Data registers, cmd_o and cmderr cleared.
- Both FSMs to idle.

DMI handshake:
- dmi_req_ready_o = !dmi_resp_valid_o; one outstanding request.
- Request accepted at cycle N → dmi_resp_valid_o high at N+1 with data.
- Response holds, data stable, until dmi_resp_ready_i.
- Zero-cycle bubble: a new request may be accepted in the cycle after the response handshake.

Register map:
- Data 8'h04..DataEnd: RW.
- AbstractCS 8'h16 read value: {3'b0, progbufsize=5'd0, 11'b0, busy[12], 1'b0, cmderr[10:8], 4'b0, datacount[3:0]=DATA_COUNT}.
- AbstractCS write: bits[10:8] are write-1-to-clear on cmderr.
- Command 8'h17: write-only, reads 0.
- Other addresses: read 0, writes ignored, no error.

cmderr:
- Codes: 0 none, 1 busy, 2 not supported, 3 exception, 4 halt/resume.
- Sticky: an error is only recorded when cmderr==0.

Access while busy:
- Any DMI access to Data, AbstractCS or Command: access dropped, read returns 0, cmderr←1 if 0.

Command write when not busy:
- cmderr!=0 → ignored.
- cmd[31:24]!=0 → cmderr←2.
- !hart_halted_i → cmderr←4.
- Otherwise latch cmd_o and enter CMD_GO.

Command FSM:
- CMD_IDLE: busy_o=0.
- CMD_GO: go_o=1 for exactly one cycle, busy_o=1 → CMD_WAIT.
- CMD_WAIT: busy_o=1.
  - hart_exception_i → cmderr←3, CMD_IDLE.
  - else hart_done_i → CMD_IDLE.
  - Exception and done in the same cycle: exception wins.
  - done/exception in CMD_GO or CMD_IDLE: ignored.
- busy_o rises the cycle after the Command-write acceptance and falls the cycle after done.

Hart data writes:
- Honoured only in CMD_WAIT with hart_data_idx_i < DATA_COUNT.
- Otherwise dropped.
- A write coincident with done is still honoured.

Reset mid-command: FSM returns to idle immediately, go_o never reissued.

Width rule: address compare uses {1'b0, addr} against 8-bit CSR constants.

Decomposition:
- dm_pkg holds:
  - dm_csr_t enum (Data0..Command values)
  - cmderr_e (3-bit)
  - dmi_op_e (2-bit)
  - abstractcs_t packed struct
  - DATA0_ADDR constant
- One sub-module: dm_cmd_fsm (CMD_IDLE/GO/WAIT, busy_o, go_o, cmderr updates).
- Register file and DMI handshake stay in dm_cmd_sequencer.

Test Plan:
- Reset, then write Data0=32'hDEADBEEF, read Data0 → resp 32'hDEADBEEF one cycle after acceptance; read AbstractCS → 32'h00000002.
- Halted hart, write Command 32'h00221002 → go_o one-cycle pulse, cmd_o=32'h00221002, busy_o=1 until cycle after hart_done_i; AbstractCS reads 32'h0 busy/cmderr.
- While busy, write Data1=5 → Data1 unchanged, AbstractCS cmderr=1; second Command write ignored; write AbstractCS 32'h700 after idle → cmderr=0.
- Command 32'h01000000 → cmderr=2, no go_o; not-halted hart with valid Command → cmderr=4, no go_o.
- During WAIT: hart writes idx1=32'h55, idx5 (out of range) dropped; done and exception same cycle → cmderr=3, busy_o=0.
- Hold dmi_resp_ready_i low 3 cycles → dmi_req_ready_o=0, response data stable; assert rst_ni=0 in CMD_WAIT → busy_o=0, go_o=0, Data regs 0 next cycle.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and constants for the debug-module abstract-command sequencer.
// CSR addresses are 8-bit; the 7-bit DMI address is zero-extended before compare.
package dm_pkg;

  typedef enum logic [7:0] {
    CSR_DATA0      = 8'h04,
    CSR_DATA11     = 8'h0F,
    CSR_ABSTRACTCS = 8'h16,
    CSR_COMMAND    = 8'h17
  } dm_csr_t;

  typedef enum logic [2:0] {
    CMDERR_NONE       = 3'd0,
    CMDERR_BUSY       = 3'd1,
    CMDERR_NOTSUP     = 3'd2,
    CMDERR_EXCEPTION  = 3'd3,
    CMDERR_HALTRESUME = 3'd4
  } cmderr_e;

  typedef enum logic [1:0] {
    DMI_NOP   = 2'd0,
    DMI_READ  = 2'd1,
    DMI_WRITE = 2'd2,
    DMI_RSVD  = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    CMD_IDLE = 2'd0,
    CMD_GO   = 2'd1,
    CMD_WAIT = 2'd2
  } cmd_state_e;

  typedef struct packed {
    logic [2:0]  zero_31_29;
    logic [4:0]  progbufsize;
    logic [10:0] zero_23_13;
    logic        busy;
    logic        zero_11;
    logic [2:0]  cmderr;
    logic [3:0]  zero_7_4;
    logic [3:0]  datacount;
  } abstractcs_t;

  localparam logic [7:0] DATA0_ADDR = 8'h04;

endpackage

// File: rtl/dm_cmd_fsm.sv
// Abstract-command launch FSM: one go pulse per accepted Command, then waits
// for done/exception. Also owns the sticky cmderr field.
module dm_cmd_fsm
  import dm_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic        busy_err_i,
  input  logic [2:0]  cmderr_w1c_i,
  input  logic        hart_halted_i,
  input  logic        hart_done_i,
  input  logic        hart_exception_i,
  output logic        go_o,
  output logic        busy_o,
  output logic [31:0] cmd_o,
  output cmderr_e     cmderr_o,
  output cmd_state_e  state_o
);

  cmd_state_e  state_q, state_d;
  logic [31:0] cmd_q, cmd_d;
  cmderr_e     cmderr_q, cmderr_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= CMD_IDLE;
      cmd_q    <= '0;
      cmderr_q <= CMDERR_NONE;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      cmderr_q <= cmderr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    cmderr_d = cmderr_q;
    go_o     = 1'b0;
    busy_o   = 1'b0;
    unique case (state_q)
      CMD_IDLE: begin
        cmderr_d = cmderr_e'(cmderr_q & ~cmderr_w1c_i);
        // A pending error blocks new commands until software clears it.
        if (cmd_we_i && (cmderr_q == CMDERR_NONE)) begin
          if (cmd_wdata_i[31:24] != 8'h00) begin
            cmderr_d = CMDERR_NOTSUP;
          end else if (!hart_halted_i) begin
            cmderr_d = CMDERR_HALTRESUME;
          end else begin
            cmd_d   = cmd_wdata_i;
            state_d = CMD_GO;
          end
        end
      end
      CMD_GO: begin
        go_o    = 1'b1;
        busy_o  = 1'b1;
        state_d = CMD_WAIT;
        if (busy_err_i && (cmderr_q == CMDERR_NONE)) cmderr_d = CMDERR_BUSY;
      end
      CMD_WAIT: begin
        busy_o = 1'b1;
        if (hart_exception_i) begin
          if (cmderr_q == CMDERR_NONE) cmderr_d = CMDERR_EXCEPTION;
          state_d = CMD_IDLE;
        end else begin
          if (busy_err_i && (cmderr_q == CMDERR_NONE)) cmderr_d = CMDERR_BUSY;
          if (hart_done_i) state_d = CMD_IDLE;
        end
      end
      default: state_d = CMD_IDLE;
    endcase
  end

  assign cmd_o    = cmd_q;
  assign cmderr_o = cmderr_q;
  assign state_o  = state_q;

endmodule

// File: rtl/dm_cmd_sequencer.sv
// Debug-module abstract-command controller: Data/AbstractCS/Command CSRs,
// the DMI request/response port and the hart-side data write path.
module dm_cmd_sequencer
  import dm_pkg::*;
#(
  parameter int DATA_COUNT = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dmi_req_valid_i,
  output logic        dmi_req_ready_o,
  input  logic [6:0]  dmi_req_addr_i,
  input  logic [1:0]  dmi_req_op_i,
  input  logic [31:0] dmi_req_data_i,
  output logic        dmi_resp_valid_o,
  input  logic        dmi_resp_ready_i,
  output logic [31:0] dmi_resp_data_o,
  output logic        go_o,
  output logic [31:0] cmd_o,
  input  logic        hart_halted_i,
  input  logic        hart_done_i,
  input  logic        hart_exception_i,
  input  logic        hart_data_we_i,
  input  logic [3:0]  hart_data_idx_i,
  input  logic [31:0] hart_data_i,
  output logic        busy_o
);

  logic [7:0]  addr_ext;
  logic [3:0]  data_idx;
  logic        is_data, is_acs, is_cmd, is_csr, is_rd, is_wr;
  logic        req_fire, cmd_we, busy_err;
  logic [2:0]  cmderr_w1c;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [31:0] data_q [DATA_COUNT];
  logic [31:0] data_d [DATA_COUNT];
  cmderr_e     cmderr;
  cmd_state_e  fsm_state;
  abstractcs_t acs;

  assign addr_ext = {1'b0, dmi_req_addr_i};
  assign data_idx = 4'(addr_ext - DATA0_ADDR);
  assign is_data  = (addr_ext >= DATA0_ADDR) && (addr_ext < (DATA0_ADDR + 8'(DATA_COUNT)));
  assign is_acs   = (addr_ext == CSR_ABSTRACTCS);
  assign is_cmd   = (addr_ext == CSR_COMMAND);
  assign is_csr   = is_data | is_acs | is_cmd;
  assign is_rd    = (dmi_req_op_i == DMI_READ);
  assign is_wr    = (dmi_req_op_i == DMI_WRITE);

  // Handshake: a request transfers when valid & ready; ready is low while a
  // response is held, so at most one request is outstanding. A response
  // transfers when resp_valid & resp_ready and frees ready for the next cycle.
  assign dmi_req_ready_o  = rst_ni & ~resp_valid_q;
  assign req_fire         = dmi_req_valid_i & dmi_req_ready_o;
  assign dmi_resp_valid_o = resp_valid_q;
  assign dmi_resp_data_o  = resp_data_q;

  assign busy_err   = req_fire & is_csr & (is_rd | is_wr) & busy_o;
  assign cmd_we     = req_fire & is_cmd & is_wr & ~busy_o;
  assign cmderr_w1c = (req_fire && is_acs && is_wr && !busy_o) ? dmi_req_data_i[10:8] : 3'b000;

  always_comb begin
    acs             = '0;
    acs.progbufsize = 5'd0;
    acs.busy        = busy_o;
    acs.cmderr      = cmderr;
    acs.datacount   = 4'(DATA_COUNT);
  end

  always_comb begin
    data_d       = data_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    if ((fsm_state == CMD_WAIT) && hart_data_we_i) begin
      for (int i = 0; i < DATA_COUNT; i++) begin
        if (hart_data_idx_i == 4'(i)) data_d[i] = hart_data_i;
      end
    end
    if (req_fire) begin
      resp_valid_d = 1'b1;
      resp_data_d  = '0;
      if (!busy_o && is_rd) begin
        if (is_acs) resp_data_d = acs;
        for (int i = 0; i < DATA_COUNT; i++) begin
          if (is_data && (data_idx == 4'(i))) resp_data_d = data_q[i];
        end
      end
      if (!busy_o && is_wr && is_data) begin
        for (int i = 0; i < DATA_COUNT; i++) begin
          if (data_idx == 4'(i)) data_d[i] = dmi_req_data_i;
        end
      end
    end else if (resp_valid_q && dmi_resp_ready_i) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      for (int i = 0; i < DATA_COUNT; i++) data_q[i] <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      data_q       <= data_d;
    end
  end

  dm_cmd_fsm u_cmd_fsm (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .cmd_we_i         (cmd_we),
    .cmd_wdata_i      (dmi_req_data_i),
    .busy_err_i       (busy_err),
    .cmderr_w1c_i     (cmderr_w1c),
    .hart_halted_i    (hart_halted_i),
    .hart_done_i      (hart_done_i),
    .hart_exception_i (hart_exception_i),
    .go_o             (go_o),
    .busy_o           (busy_o),
    .cmd_o            (cmd_o),
    .cmderr_o         (cmderr),
    .state_o          (fsm_state)
  );

endmodule

// File: tb/tb_dm_cmd_sequencer.sv
// Directed bench for dm_cmd_sequencer with a cycle-level reference model and
// literal checks on key read-back values.
module tb_dm_cmd_sequencer;

  localparam int DC = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        dmi_req_valid_i;
  logic        dmi_req_ready_o;
  logic [6:0]  dmi_req_addr_i;
  logic [1:0]  dmi_req_op_i;
  logic [31:0] dmi_req_data_i;
  logic        dmi_resp_valid_o;
  logic        dmi_resp_ready_i;
  logic [31:0] dmi_resp_data_o;
  logic        go_o;
  logic [31:0] cmd_o;
  logic        hart_halted_i;
  logic        hart_done_i;
  logic        hart_exception_i;
  logic        hart_data_we_i;
  logic [3:0]  hart_data_idx_i;
  logic [31:0] hart_data_i;
  logic        busy_o;

  dm_cmd_sequencer #(.DATA_COUNT(DC)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .dmi_req_valid_i  (dmi_req_valid_i),
    .dmi_req_ready_o  (dmi_req_ready_o),
    .dmi_req_addr_i   (dmi_req_addr_i),
    .dmi_req_op_i     (dmi_req_op_i),
    .dmi_req_data_i   (dmi_req_data_i),
    .dmi_resp_valid_o (dmi_resp_valid_o),
    .dmi_resp_ready_i (dmi_resp_ready_i),
    .dmi_resp_data_o  (dmi_resp_data_o),
    .go_o             (go_o),
    .cmd_o            (cmd_o),
    .hart_halted_i    (hart_halted_i),
    .hart_done_i      (hart_done_i),
    .hart_exception_i (hart_exception_i),
    .hart_data_we_i   (hart_data_we_i),
    .hart_data_idx_i  (hart_data_idx_i),
    .hart_data_i      (hart_data_i),
    .busy_o           (busy_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  int tests_run    = 0;
  int tests_failed = 0;
  int go_cnt       = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          model_live = 1'b0;
  bit          m_resp_valid;
  logic [31:0] m_resp_data;
  logic [31:0] m_data [DC];
  int          m_cmderr;
  bit          m_busy;
  bit          m_go;
  logic [31:0] m_cmd;

  always @(posedge clk_i) begin
    if (!rst_ni) begin
      model_live   = 1'b1;
      m_resp_valid = 1'b0;
      m_resp_data  = '0;
      for (int i = 0; i < DC; i++) m_data[i] = '0;
      m_cmderr     = 0;
      m_busy       = 1'b0;
      m_go         = 1'b0;
      m_cmd        = '0;
    end else if (model_live) begin
      bit cur_busy, cur_wait, new_go, accept, rd, wr, is_data, is_acs, is_cmd;
      int a;
      cur_busy = m_busy;
      cur_wait = m_busy && !m_go;
      new_go   = 1'b0;
      // hart side: data writes and completion, only once the pulse has gone out
      if (cur_wait && hart_data_we_i && (int'(hart_data_idx_i) < DC))
        m_data[int'(hart_data_idx_i)] = hart_data_i;
      if (cur_wait && hart_exception_i) begin
        if (m_cmderr == 0) m_cmderr = 3;
        m_busy = 1'b0;
      end else if (cur_wait && hart_done_i) begin
        m_busy = 1'b0;
      end
      // DMI side
      accept  = dmi_req_valid_i && !m_resp_valid;
      a       = int'(dmi_req_addr_i);
      is_data = (a >= 4) && (a < 4 + DC);
      is_acs  = (a == 'h16);
      is_cmd  = (a == 'h17);
      rd      = (dmi_req_op_i == 2'd1);
      wr      = (dmi_req_op_i == 2'd2);
      if (accept) begin
        m_resp_valid = 1'b1;
        m_resp_data  = '0;
        if ((rd || wr) && (is_data || is_acs || is_cmd)) begin
          if (cur_busy) begin
            if (m_cmderr == 0) m_cmderr = 1;
          end else if (rd) begin
            if (is_data) m_resp_data = m_data[a - 4];
            if (is_acs)  m_resp_data = 32'(m_cmderr * 256 + DC);
          end else begin
            if (is_data) m_data[a - 4] = dmi_req_data_i;
            if (is_acs)  m_cmderr = m_cmderr & ~int'(dmi_req_data_i[10:8]);
            if (is_cmd && m_cmderr == 0) begin
              if (dmi_req_data_i[31:24] != 0) m_cmderr = 2;
              else if (!hart_halted_i)        m_cmderr = 4;
              else begin
                m_cmd  = dmi_req_data_i;
                new_go = 1'b1;
                m_busy = 1'b1;
              end
            end
          end
        end
      end else if (m_resp_valid && dmi_resp_ready_i) begin
        m_resp_valid = 1'b0;
      end
      m_go = new_go;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk_i) begin
    if (model_live) begin
      check("req_ready",  32'(dmi_req_ready_o),  32'(rst_ni && !m_resp_valid));
      check("resp_valid", 32'(dmi_resp_valid_o), 32'(m_resp_valid));
      if (m_resp_valid) check("resp_data", dmi_resp_data_o, m_resp_data);
      check("go",   32'(go_o),   32'(m_go));
      check("busy", 32'(busy_o), 32'(m_busy));
      check("cmd",  cmd_o, m_cmd);
    end
    if (go_o === 1'b1) go_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic dmi_xfer(input logic [1:0] op, input logic [6:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata);
    int n;
    dmi_req_valid_i = 1'b1;
    dmi_req_op_i    = op;
    dmi_req_addr_i  = addr;
    dmi_req_data_i  = wdata;
    n = 0;
    while (!dmi_req_ready_o && n < 20) begin
      @(posedge clk_i); #1; n++;
    end
    if (!dmi_req_ready_o) begin
      tests_run++; tests_failed++;
      $display("FAIL req_ready_timeout: got 0 expected 1 at %0t", $time);
    end
    @(posedge clk_i); #1;
    dmi_req_valid_i = 1'b0;
    dmi_req_op_i    = 2'd0;
    n = 0;
    while (!dmi_resp_valid_o && n < 20) begin
      @(posedge clk_i); #1; n++;
    end
    if (!dmi_resp_valid_o) begin
      tests_run++; tests_failed++;
      $display("FAIL resp_valid_timeout: got 0 expected 1 at %0t", $time);
    end
    rdata = dmi_resp_data_o;
    @(posedge clk_i); #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic hart_pulse(input logic we, input logic [3:0] idx, input logic [31:0] d,
                            input logic done, input logic exc);
    hart_data_we_i   = we;
    hart_data_idx_i  = idx;
    hart_data_i      = d;
    hart_done_i      = done;
    hart_exception_i = exc;
    @(posedge clk_i); #1;
    hart_data_we_i   = 1'b0;
    hart_done_i      = 1'b0;
    hart_exception_i = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] rd;

  initial begin
    rst_ni           = 1'b0;
    dmi_req_valid_i  = 1'b0;
    dmi_req_addr_i   = '0;
    dmi_req_op_i     = 2'd0;
    dmi_req_data_i   = '0;
    dmi_resp_ready_i = 1'b1;
    hart_halted_i    = 1'b0;
    hart_done_i      = 1'b0;
    hart_exception_i = 1'b0;
    hart_data_we_i   = 1'b0;
    hart_data_idx_i  = '0;
    hart_data_i      = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_req_ready",  32'(dmi_req_ready_o),  32'd0);
    check("rst_resp_valid", 32'(dmi_resp_valid_o), 32'd0);
    check("rst_resp_data",  dmi_resp_data_o,       32'd0);
    check("rst_go",         32'(go_o),             32'd0);
    check("rst_busy",       32'(busy_o),           32'd0);
    check("rst_cmd",        cmd_o,                 32'd0);
    rst_ni = 1'b1;
    idle_cycles(1);

    // basic data register and AbstractCS access
    dmi_xfer(2'd2, 7'h04, 32'hDEADBEEF, rd);
    dmi_xfer(2'd1, 7'h04, 32'h0, rd);
    check("rd_data0", rd, 32'hDEADBEEF);
    dmi_xfer(2'd1, 7'h16, 32'h0, rd);
    check("rd_acs_idle", rd, 32'h00000002);
    dmi_xfer(2'd3, 7'h04, 32'h12345678, rd);
    check("rsvd_op_data", rd, 32'h0);

    // first command, with illegal accesses while it runs
    hart_halted_i = 1'b1;
    dmi_xfer(2'd2, 7'h17, 32'h00221002, rd);
    check("cmd_latched", cmd_o, 32'h00221002);
    dmi_xfer(2'd1, 7'h16, 32'h0, rd);
    check("rd_acs_busy", rd, 32'h0);
    dmi_xfer(2'd2, 7'h05, 32'h5, rd);
    dmi_xfer(2'd2, 7'h17, 32'h00221003, rd);
    hart_pulse(1'b1, 4'd1, 32'h55, 1'b0, 1'b0);
    hart_pulse(1'b1, 4'd5, 32'h77, 1'b0, 1'b0);
    hart_pulse(1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
    check("busy_after_done", 32'(busy_o), 32'd0);
    dmi_xfer(2'd1, 7'h05, 32'h0, rd);
    check("rd_data1_hart", rd, 32'h00000055);
    dmi_xfer(2'd1, 7'h16, 32'h0, rd);
    check("rd_acs_err_busy", rd, 32'h00000102);
    dmi_xfer(2'd2, 7'h16, 32'h00000700, rd);
    dmi_xfer(2'd1, 7'h16, 32'h0, rd);
    check("rd_acs_cleared", rd, 32'h00000002);
    check("go_count_1", 32'(go_cnt), 32'd1);

    // second command ends with done and exception together
    dmi_xfer(2'd2, 7'h17, 32'h00221002, rd);
    hart_pulse(1'b0, 4'd0, 32'h0, 1'b1, 1'b1);
    check("busy_after_exc", 32'(busy_o), 32'd0);
    dmi_xfer(2'd1, 7'h16, 32'h0, rd);
    check("rd_acs_exc", rd, 32'h00000302);
    dmi_xfer(2'd2, 7'h16, 32'h00000700, rd);

    // rejected commands
    dmi_xfer(2'd2, 7'h17, 32'h01000000, rd);
    dmi_xfer(2'd1, 7'h16, 32'h0, rd);
    check("rd_acs_notsup", rd, 32'h00000202);
    dmi_xfer(2'd2, 7'h16, 32'h00000700, rd);
    hart_halted_i = 1'b0;
    dmi_xfer(2'd2, 7'h17, 32'h00221002, rd);
    dmi_xfer(2'd1, 7'h16, 32'h0, rd);
    check("rd_acs_halt", rd, 32'h00000402);
    dmi_xfer(2'd2, 7'h16, 32'h00000700, rd);
    hart_halted_i = 1'b1;
    check("go_count_2", 32'(go_cnt), 32'd2);

    // response back-pressure
    dmi_resp_ready_i = 1'b0;
    dmi_req_valid_i  = 1'b1;
    dmi_req_op_i     = 2'd1;
    dmi_req_addr_i   = 7'h04;
    @(posedge clk_i); #1;
    dmi_req_valid_i  = 1'b0;
    dmi_req_op_i     = 2'd0;
    for (int i = 0; i < 3; i++) begin
      check("hold_req_ready",  32'(dmi_req_ready_o),  32'd0);
      check("hold_resp_valid", 32'(dmi_resp_valid_o), 32'd1);
      check("hold_resp_data",  dmi_resp_data_o,       32'hDEADBEEF);
      @(posedge clk_i); #1;
    end
    dmi_resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    check("bubble_req_ready", 32'(dmi_req_ready_o), 32'd1);

    // reset while a command is in flight
    dmi_xfer(2'd2, 7'h17, 32'h00221002, rd);
    check("busy_before_rst", 32'(busy_o), 32'd1);
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_go",   32'(go_o),   32'd0);
    check("midrst_cmd",  cmd_o,       32'd0);
    rst_ni = 1'b1;
    idle_cycles(4);
    check("go_count_3", 32'(go_cnt), 32'd3);
    dmi_xfer(2'd1, 7'h04, 32'h0, rd);
    check("rd_data0_rst", rd, 32'h0);
    dmi_xfer(2'd1, 7'h05, 32'h0, rd);
    check("rd_data1_rst", rd, 32'h0);
    dmi_xfer(2'd1, 7'h16, 32'h0, rd);
    check("rd_acs_rst", rd, 32'h00000002);
    dmi_xfer(2'd1, 7'h17, 32'h0, rd);
    check("rd_cmd_wo", rd, 32'h0);
    idle_cycles(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
